// File: rtl/matmul_apb_slave_if.sv
// rtl/matmul_apb_slave_if.sv - APB bus bundle between the bus master and the matmul register file
interface matmul_apb_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_DIM    = 4
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [MAX_DIM-1:0]    pstrb_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [BUS_WIDTH-1:0]  pwdata_i;
    logic                  pready_o;
    logic                  pslverr_o;
    logic [BUS_WIDTH-1:0]  prdata_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
        output pready_o, pslverr_o, prdata_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, paddr_i, pwdata_i,
        input  pready_o, pslverr_o, prdata_o
    );
endinterface

// File: rtl/matmul_apb_slave.sv
// rtl/matmul_apb_slave.sv - APB completer and register file for the matmul accelerator
module matmul_apb_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 4,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int LW        = $clog2(MAX_DIM),
    localparam int IDXW      = 2 * LW
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    matmul_apb_slave_if.slave            apb,
    output logic                         busy_o,
    output logic                         start_o,
    output logic [15:0]                  control_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] opa_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] opb_o,
    input  logic                         core_done_i,
    input  logic [BUS_WIDTH-1:0]         flags_i,
    input  logic                         sp_we_i,
    input  logic [IDXW-1:0]              sp_idx_i,
    input  logic [BUS_WIDTH-1:0]         sp_wdata_i
);
    // Bits 0, 6, 7, 14, 15 of CONTROL are never stored.
    localparam logic [15:0] CTRL_MASK = 16'h3F3E;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 r_state;
    logic                   r_pready;
    logic                   r_pslverr;
    logic [BUS_WIDTH-1:0]   r_prdata;
    logic                   r_busy;
    logic                   r_start;
    logic [15:0]            r_control;
    logic [BUS_WIDTH-1:0]   r_flags;
    logic [BUS_WIDTH-1:0]   r_opa [MAX_DIM];
    logic [BUS_WIDTH-1:0]   r_opb [MAX_DIM];
    logic [BUS_WIDTH-1:0]   r_sp  [4][MAX_DIM*MAX_DIM];

    logic [2:0]             w_reg;
    logic [IDXW-1:0]        w_idx;
    logic [LW-1:0]          w_line;
    logic                   w_line_hi;
    logic                   w_is_ctrl;
    logic                   w_is_op;
    logic                   w_err;
    logic [BUS_WIDTH-1:0]   w_wmask;
    logic [BUS_WIDTH-1:0]   w_rdata;
    logic [15:0]            w_ctrl_next;
    logic                   w_start;
    logic                   w_unused_addr;

    assign w_reg         = apb.paddr_i[4:2];
    assign w_idx         = apb.paddr_i[5 +: IDXW];
    assign w_line        = w_idx[LW-1:0];
    assign w_line_hi     = |w_idx[IDXW-1:LW];
    assign w_is_ctrl     = (w_reg == 3'd0);
    assign w_is_op       = (w_reg == 3'd1) || (w_reg == 3'd2);
    assign w_unused_addr = ^apb.paddr_i[ADDR_WIDTH-1:5+IDXW];

    // Misaligned, bad operand line, read-only target, or config write while the core runs.
    assign w_err = (|apb.paddr_i[1:0])
                 || (w_is_op && w_line_hi)
                 || (apb.pwrite_i && (w_reg == 3'd3 || w_reg[2]))
                 || (apb.pwrite_i && r_busy && (w_is_ctrl || w_is_op));

    // Expand the per-lane strobes into a per-bit write mask.
    for (genvar b = 0; b < BUS_WIDTH; b++) begin : g_mask
        assign w_wmask[b] = apb.pstrb_i[b / DATA_WIDTH];
    end

    assign w_ctrl_next = ((r_control & ~w_wmask[15:0]) | (apb.pwdata_i[15:0] & w_wmask[15:0])) & CTRL_MASK;
    assign w_start     = apb.pwdata_i[0] & w_wmask[0];

    // Read mux over the currently addressed register.
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            3'd0:    w_rdata[15:0] = r_control;
            3'd1:    w_rdata = r_opa[w_line];
            3'd2:    w_rdata = r_opb[w_line];
            3'd3:    w_rdata = r_flags;
            default: w_rdata = r_sp[w_reg[1:0]][w_idx];
        endcase
    end

    // Transfer FSM with registered bus response, commit of CONTROL/OPERAND writes, busy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_busy    <= 1'b0;
            r_start   <= 1'b0;
            r_control <= '0;
            r_flags   <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
                r_opa[i] <= '0;
                r_opb[i] <= '0;
            end
        end else begin
            r_start <= 1'b0;
            if (r_busy && core_done_i) begin
                r_flags <= flags_i;
                r_busy  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (apb.psel_i && apb.penable_i && !r_pready) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!apb.psel_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state   <= S_RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= w_err ? '0 : w_rdata;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    if (apb.pwrite_i && !r_pslverr) begin
                        if (w_is_ctrl) begin
                            r_control <= w_ctrl_next;
                            if (w_start) begin
                                r_busy  <= 1'b1;
                                r_start <= 1'b1;
                            end
                        end
                        if (w_reg == 3'd1) r_opa[w_line] <= (r_opa[w_line] & ~w_wmask) | (apb.pwdata_i & w_wmask);
                        if (w_reg == 3'd2) r_opb[w_line] <= (r_opb[w_line] & ~w_wmask) | (apb.pwdata_i & w_wmask);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Core result writes into the scratchpad selected by write_target.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < 4; t++)
                for (int e = 0; e < MAX_DIM*MAX_DIM; e++)
                    r_sp[t][e] <= '0;
        end else if (r_busy && sp_we_i) begin
            r_sp[r_control[3:2]][sp_idx_i] <= sp_wdata_i;
        end
    end

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_lines
        assign opa_o[i*BUS_WIDTH +: BUS_WIDTH] = r_opa[i];
        assign opb_o[i*BUS_WIDTH +: BUS_WIDTH] = r_opb[i];
    end

    assign apb.pready_o  = r_pready;
    assign apb.pslverr_o = r_pslverr;
    assign apb.prdata_o  = r_prdata;
    assign busy_o        = r_busy;
    assign start_o       = r_start;
    assign control_o     = r_control;
endmodule
